// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision divider: operand class codes,
// number-format constants and the divider FSM state encoding.
package fp_pkg;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_NAN     = 32'hFFFF_FFFF;
    localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'b000,
        CLS_SUBN = 3'b001,
        CLS_NORM = 3'b011,
        CLS_INF  = 3'b100,
        CLS_NAN  = 3'b110
    } fp_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_NORM,
        ST_DIV,
        ST_PACK,
        ST_DONE
    } fp_state_e;

endpackage

// File: rtl/fp_classify.sv
// Classifies one single-precision operand and counts the leading zeros of its
// 24-bit significand with the hidden bit cleared (normalising shift for subnormals).
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] op_i,
    output logic        sign_o,
    output logic [2:0]  cls_o,
    output logic [4:0]  lz_o
);

    always_comb begin
        sign_o = op_i[31];
        if (op_i[30:23] == 8'h00) begin
            cls_o = (op_i[22:0] == '0) ? CLS_ZERO : CLS_SUBN;
        end else if (op_i[30:23] == 8'hFF) begin
            cls_o = (op_i[22:0] == '0) ? CLS_INF : CLS_NAN;
        end else begin
            cls_o = CLS_NORM;
        end
    end

    // The last (highest) set bit wins, giving the count for {1'b0, mantissa}
    always_comb begin
        lz_o = 5'd24;
        for (int i = 0; i < 23; i++) begin
            if (op_i[i]) begin
                lz_o = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider: restoring radix-2 mantissa division,
// truncating rounding, gradual underflow, overflow to signed infinity.
module fp_divider
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = FP_BIAS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    output logic [31:0] o_res
);

    localparam int SIG_W = MANT_W + 1;
    localparam int EMAX  = (1 << EXP_W) - 1;

    fp_state_e          state_q;
    logic [31:0]        a_q, b_q, res_q;
    logic               valid_q, sign_q;
    logic [SIG_W:0]     rem_q;
    logic [MANT_W:0]    divsr_q, quo_q;
    logic signed [10:0] exp_q;
    logic [4:0]         cnt_q;

    logic               signA, signB;
    logic [2:0]         clsA, clsB;
    logic [4:0]         lzA, lzB;

    logic               specialHit_d;
    logic [31:0]        specialRes_d, packRes_d;
    logic [MANT_W:0]    sigA_d, sigB_d, remDiff_d;
    logic signed [10:0] expA_d, expB_d, er_d, shAmt_d;
    logic [MANT_W-1:0]  subn_d;

    fp_classify uClassA (.op_i(a_q), .sign_o(signA), .cls_o(clsA), .lz_o(lzA));
    fp_classify uClassB (.op_i(b_q), .sign_o(signB), .cls_o(clsB), .lz_o(lzB));

    always_comb begin
        specialHit_d = 1'b1;
        specialRes_d = FP_NAN;
        if (clsA == CLS_NAN || clsB == CLS_NAN) begin
            specialRes_d = FP_NAN;
        end else if ((clsA == CLS_INF && clsB == CLS_INF) ||
                     (clsA == CLS_ZERO && clsB == CLS_ZERO)) begin
            specialRes_d = FP_NAN;
        end else if (clsA == CLS_INF || clsB == CLS_ZERO) begin
            specialRes_d = {signA ^ signB, FP_INF_MAG};
        end else if (clsA == CLS_ZERO || clsB == CLS_INF) begin
            specialRes_d = {signA ^ signB, 31'b0};
        end else begin
            specialHit_d = 1'b0;
        end
    end

    // Subnormals are normalised so both significands carry a leading one
    always_comb begin
        sigA_d = (clsA == CLS_SUBN) ? ({1'b0, a_q[MANT_W-1:0]} << lzA) : {1'b1, a_q[MANT_W-1:0]};
        sigB_d = (clsB == CLS_SUBN) ? ({1'b0, b_q[MANT_W-1:0]} << lzB) : {1'b1, b_q[MANT_W-1:0]};
        expA_d = (clsA == CLS_SUBN) ? 11'sd1 - $signed({6'b0, lzA}) : $signed({3'b000, a_q[MANT_W +: EXP_W]});
        expB_d = (clsB == CLS_SUBN) ? 11'sd1 - $signed({6'b0, lzB}) : $signed({3'b000, b_q[MANT_W +: EXP_W]});
        er_d   = expA_d - expB_d + $signed(11'(BIAS));
    end

    assign remDiff_d = (MANT_W + 1)'(rem_q - {1'b0, divsr_q});
    assign shAmt_d   = 11'sd1 - exp_q;
    assign subn_d    = MANT_W'(quo_q >> shAmt_d[4:0]);

    always_comb begin
        if (exp_q >= $signed(11'(EMAX))) begin
            packRes_d = {sign_q, FP_INF_MAG};
        end else if (exp_q >= 11'sd1) begin
            packRes_d = {sign_q, exp_q[EXP_W-1:0], quo_q[MANT_W-1:0]};
        end else if (shAmt_d <= 11'sd23) begin
            packRes_d = {sign_q, 8'h00, subn_d};
        end else begin
            packRes_d = {sign_q, 31'b0};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            divsr_q <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        state_q <= ST_UNPACK;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_UNPACK: begin
                    sign_q <= signA ^ signB;
                    if (specialHit_d) begin
                        res_q   <= specialRes_d;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    // Pre-shifting the dividend keeps the quotient MSB set
                    if (sigA_d < sigB_d) begin
                        rem_q <= {sigA_d, 1'b0};
                        exp_q <= er_d - 11'sd1;
                    end else begin
                        rem_q <= {1'b0, sigA_d};
                        exp_q <= er_d;
                    end
                    divsr_q <= sigB_d;
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    if (rem_q >= {1'b0, divsr_q}) begin
                        quo_q <= {quo_q[MANT_W-1:0], 1'b1};
                        rem_q <= {remDiff_d, 1'b0};
                    end else begin
                        quo_q <= {quo_q[MANT_W-1:0], 1'b0};
                        rem_q <= {rem_q[MANT_W:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MANT_W)) begin
                        state_q <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    res_q   <= packRes_d;
                    valid_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign o_valid = valid_q;
    assign o_res   = res_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: the driver queues hand-computed results and
// expected completion cycles, a negedge monitor pops and compares them.
module tb_fp_divider;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, o_valid;
    logic [31:0] i_a, i_b, o_res;

    int cyc      = 0;
    int passCnt  = 0;
    int totalCnt = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] tblA   [8] = '{32'h0000_0000, 32'hBF80_0000, 32'h7F80_0000, 32'h3F80_0000,
                                32'h7FC0_0000, 32'h0000_0001, 32'h0080_0000, 32'h0000_0001};
    logic [31:0] tblB   [8] = '{32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h3F80_0000, 32'h0000_0001, 32'h4000_0000, 32'h4000_0000};
    logic [31:0] tblRes [8] = '{32'hFFFF_FFFF, 32'hFF80_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h3F80_0000, 32'h0040_0000, 32'h0000_0000};
    int          tblLat [8] = '{1, 1, 1, 1, 1, 27, 27, 27};

    fp_divider dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .o_res   (o_res)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        totalCnt++;
        if (act === req) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Waits for o_ready, issues one operation and optionally queues its result
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int lat, input bit track);
        int   waitCnt;
        exp_t e;
        waitCnt = 0;
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        while (!o_ready && waitCnt < 200) begin
            @(posedge i_clk);
            #1;
            waitCnt++;
        end
        if (!o_ready) begin
            checkOutput("ready_timeout", {31'b0, o_ready}, 32'd1);
            i_valid = 1'b0;
            return;
        end
        @(posedge i_clk);
        #1;
        if (track) begin
            e.res = expRes;
            e.cyc = cyc + lat;
            expQ.push_back(e);
        end
        i_valid = 1'b0;
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (!i_rst && o_valid) begin
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("[TB] FAIL unexpected_valid: got o_res=%h with no operation pending (cycle %0d)", o_res, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", o_res, e.res);
                checkOutput("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int busyErr;
        int n;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        #2;
        checkOutput("reset_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("reset_res", o_res, 32'd0);
        checkOutput("reset_ready", {31'b0, o_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        $display("[TB] 6/2 with busy-ready check");
        applyStimulus(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 1'b1);
        busyErr = 0;
        repeat (27) begin
            if (o_ready) busyErr++;
            @(posedge i_clk);
            #1;
        end
        checkOutput("busy_ready", 32'(busyErr), 32'd0);
        checkOutput("done_ready", {31'b0, o_ready}, 32'd1);

        $display("[TB] back-to-back 1/3 and overflow");
        applyStimulus(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 27, 1'b1);
        applyStimulus(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 27, 1'b1);

        $display("[TB] special and subnormal table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tblA[i], tblB[i], tblRes[i], tblLat[i], 1'b1);
            if (i % 2 == 0) begin
                repeat (3) @(posedge i_clk);
                #1;
            end
        end

        $display("[TB] operands changing while busy");
        applyStimulus(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 1'b1);
        n = 0;
        i_valid = 1'b1;
        while (!o_ready && n < 100) begin
            i_a = 32'h3F80_0000 + 32'(n);
            i_b = 32'h4000_0000 ^ 32'(n);
            @(posedge i_clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        $display("[TB] reset during division");
        applyStimulus(32'h3F80_0000, 32'h4040_0000, 32'h0, 27, 1'b0);
        repeat (10) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("abort_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("abort_res", o_res, 32'd0);
        checkOutput("abort_ready", {31'b0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        applyStimulus(32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 27, 1'b1);

        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("res_hold", o_res, 32'h4000_0000);
        checkOutput("valid_idle", {31'b0, o_valid}, 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 single-precision divider (o_res = i_a / i_b); the inverse-operation companion to the team's combinational single-cycle multiplier.
- Uses a radix-2 restoring mantissa divider over multiple cycles, with a valid/ready handshake.
- Follows the same number conventions as the multiplier: round-toward-zero (truncate), gradual underflow to subnormals, overflow to signed infinity, NaN = 32'hFFFF_FFFF.

Parameters:
- EXP_W, 8: exponent width; only the default is verified.
- MANT_W, 23: stored mantissa width; quotient iterations = MANT_W+1.
- BIAS, 127: exponent bias.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operands present.
- o_ready  out  1  divider can accept; i_a/i_b are captured on an edge where i_valid & o_ready.
- i_a  in  32  dividend.
- i_b  in  32  divisor.
- o_valid  out  1  o_res is valid this cycle (exactly one cycle per operation).
- o_res  out  32  quotient; held until the next result is written.

Behaviour:
- Reset (asynchronous): state=IDLE, o_valid=0, o_res=0, all internal registers 0.
- Reset mid-operation aborts the operation; no o_valid is produced for it.
- o_ready=1 in IDLE and DONE, 0 otherwise. Accepting in DONE allows back-to-back operations.
- States:
  - IDLE: accept -> UNPACK.
  - UNPACK: classify both operands. Codes: ZERO=000, SUBN=001, NORM=011, INF=100, NAN=110. Any special case -> write o_res, go to DONE. Otherwise -> NORM.
  - NORM: build 24-bit mantissas. Hidden bit is 1 for NORM, 0 for SUBN. Left-shift each SUBN mantissa by its leading-zero count (combinational LZC). Effective exponent: NORM = E; SUBN = 1-lz; held signed in 11 bits. If ma<mb, set ma<<=1 and decrement the result exponent. Result exponent er = Ea'-Eb'+BIAS. -> DIV with cnt=0.
  - DIV: one quotient bit per cycle, MSB first. Remainder r starts at ma. Each cycle: if r>=mb then q bit=1 and r=r-mb, else q bit=0; then r<<=1. After MANT_W+1 cycles -> PACK. q[23] is guaranteed 1.
  - PACK:
    - er>=255: o_res={s,8'hFF,23'b0}.
    - er>=1: {s,er[7:0],q[22:0]}.
    - 1-er in 1..23: {s,8'h00,(q>>(1-er))[22:0]}, truncated.
    - 1-er>23: {s,31'b0}.
    - In all cases -> DONE.
  - DONE: o_valid=1 for one cycle; accept -> UNPACK, else -> IDLE.
- Sign: s = a[31]^b[31]. Special results, checked in priority order:
  - Either operand NaN -> FFFF_FFFF.
  - INF/INF or ZERO/ZERO -> FFFF_FFFF.
  - INF/finite -> {s,8'hFF,0}.
  - finite nonzero / ZERO -> {s,8'hFF,0}.
  - ZERO/nonzero -> {s,31'b0}.
  - finite/INF -> {s,31'b0}.
- Latency, with the accept at edge k:
  - Special case: o_valid is high in the cycle after edge k+1.
  - Normal case: o_valid is high in the cycle after edge k+27 (MANT_W+4 edges after k).
  - Latency is fixed and independent of the data.
- i_a/i_b are ignored while o_ready=0.
- o_res changes only on the edge entering DONE.

Decomposition:
- Shared package fp_pkg holds:
  - class codes (ZERO, SUBN, NORM, INF, NAN);
  - FP_BIAS=127, FP_NAN=32'hFFFF_FFFF, FP_INF_MAG=31'h7F80_0000;
  - the state enum (IDLE, UNPACK, NORM, DIV, PACK, DONE).
- One natural sub-module: fp_classify (32-bit input -> 3-bit class code plus 5-bit leading-zero count of the mantissa). It is instantiated twice.
- The mantissa datapath and FSM stay in fp_divider.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> o_res=0x40400000; o_valid exactly 27 edges after accept; o_ready low throughout.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated). Back-to-back accept in DONE of 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 (overflow).
- Special cases, each with 1-cycle latency:
  - 0x00000000 / 0x00000000 -> 0xFFFFFFFF.
  - 0xBF800000 / 0x00000000 -> 0xFF800000.
  - 0x7F800000 / 0x7F800000 -> 0xFFFFFFFF.
  - 0x3F800000 / 0xFF800000 -> 0x80000000.
- Subnormals:
  - 0x00000001 / 0x00000001 -> 0x3F800000.
  - 0x00800000 / 0x40000000 -> 0x00400000.
  - 0x00000001 / 0x40000000 -> 0x00000000.
- Assert i_rst mid-DIV (cycle 10) -> o_valid=0, o_res=0, o_ready=1 immediately. Then 0x41200000 / 0x40A00000 -> 0x40000000 with normal latency.
- Hold i_valid high with changing operands while busy -> inputs ignored; only the captured operation's result appears.
